// File: rtl/dac_spi_out.sv
// Dual-channel SPI DAC serialiser: resynchronises the X/Y beam coordinates into clk
// and streams 16-bit frames on two data lines that share SCLK and SYNC.
module dac_spi_out #(
    parameter int OUT_WIDTH  = 8,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [OUT_WIDTH-1:0] xch_in,
    input  logic [OUT_WIDTH-1:0] ych_in,
    output logic                 dac_sclk,
    output logic                 dac_sync_n,
    output logic                 dac_dx,
    output logic                 dac_dy,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    // Frame layout: 2 don't-care bits, 2 power-down bits (00), 12-bit code left-aligned.
    function automatic logic [15:0] make_frame(input logic [OUT_WIDTH-1:0] c);
        logic [15:0] w;
        w = '0;
        w[11 -: OUT_WIDTH] = c;
        return w;
    endfunction

    logic [OUT_WIDTH-1:0] x_s1, x_s2, x_s3, x_stable;
    logic [OUT_WIDTH-1:0] y_s1, y_s2, y_s3, y_stable;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [3:0]         bit_cnt, bit_nxt;
    logic               last_fall, last_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               sclk_nxt, sync_nxt, dx_nxt, dy_nxt, busy_nxt, done_nxt;
    logic [15:0]        sr_x, sr_y, srx_nxt, sry_nxt;
    logic [15:0]        frame_x, frame_y;

    // Stage boundary: two-flop synchroniser plus a compare register; the stable copy
    // only updates when two consecutive synchronised samples agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_s1 <= '0; x_s2 <= '0; x_s3 <= '0; x_stable <= '0;
            y_s1 <= '0; y_s2 <= '0; y_s3 <= '0; y_stable <= '0;
        end else begin
            x_s1 <= xch_in;
            x_s2 <= x_s1;
            x_s3 <= x_s2;
            y_s1 <= ych_in;
            y_s2 <= y_s1;
            y_s3 <= y_s2;
            if (x_s2 == x_s3) x_stable <= x_s2;
            if (y_s2 == y_s3) y_stable <= y_s2;
        end
    end

    assign frame_x = make_frame(x_stable);
    assign frame_y = make_frame(y_stable);

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        last_nxt  = last_fall;
        gap_nxt   = gap_cnt;
        sclk_nxt  = dac_sclk;
        sync_nxt  = dac_sync_n;
        dx_nxt    = dac_dx;
        dy_nxt    = dac_dy;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        srx_nxt   = sr_x;
        sry_nxt   = sr_y;
        case (state)
            IDLE: begin
                sclk_nxt = 1'b1;
                sync_nxt = 1'b1;
                busy_nxt = 1'b0;
                if (en) begin
                    srx_nxt   = frame_x;
                    sry_nxt   = frame_y;
                    dx_nxt    = frame_x[15];
                    dy_nxt    = frame_y[15];
                    sync_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    div_nxt   = '0;
                    bit_nxt   = '0;
                    last_nxt  = 1'b0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_nxt  = '0;
                    sclk_nxt = ~dac_sclk;
                    if (dac_sclk) begin
                        // Falling edge: DAC samples; remember when the 16th has gone by.
                        if (bit_cnt == 4'd15) last_nxt = 1'b1;
                        else                  bit_nxt  = bit_cnt + 4'd1;
                    end else if (last_fall) begin
                        sync_nxt  = 1'b1;
                        dx_nxt    = 1'b0;
                        dy_nxt    = 1'b0;
                        gap_nxt   = '0;
                        state_nxt = GAP;
                    end else begin
                        srx_nxt = {sr_x[14:0], 1'b0};
                        sry_nxt = {sr_y[14:0], 1'b0};
                        dx_nxt  = sr_x[14];
                        dy_nxt  = sr_y[14];
                    end
                end else begin
                    div_nxt = div_cnt + DIV_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage boundary: control and pin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            last_fall  <= 1'b0;
            gap_cnt    <= '0;
            dac_sclk   <= 1'b1;
            dac_sync_n <= 1'b1;
            dac_dx     <= 1'b0;
            dac_dy     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            last_fall  <= last_nxt;
            gap_cnt    <= gap_nxt;
            dac_sclk   <= sclk_nxt;
            dac_sync_n <= sync_nxt;
            dac_dx     <= dx_nxt;
            dac_dy     <= dy_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        sr_x <= srx_nxt;
        sr_y <= sry_nxt;
    end

endmodule

// File: tb/tb_dac_spi_out.sv
// Directed bench for dac_spi_out: vector table of coordinate/frame pairs plus
// hand-written sequences for reset, mid-frame update, CDC glitch and enable drop.
module tb_dac_spi_out;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [7:0] xch_in = 8'h00;
    logic [7:0] ych_in = 8'h00;
    logic       dac_sclk, dac_sync_n, dac_dx, dac_dy, busy, frame_done;

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;

    dac_spi_out #(.OUT_WIDTH(8), .CLK_DIV(2), .GAP_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .en(en), .xch_in(xch_in), .ych_in(ych_in),
        .dac_sclk(dac_sclk), .dac_sync_n(dac_sync_n), .dac_dx(dac_dx), .dac_dy(dac_dy),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] wx;
        logic [15:0] wy;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Waits for the next frame start, collects the words sampled on falling SCLK,
    // and returns once frame_done is seen. act_kind: 1 set xch_in, 2 drop en,
    // 3 one-cycle reset, applied right after falling edge number act_fall.
    task automatic capture(input int act_fall, input int act_kind, input logic [7:0] act_val,
                           output logic [15:0] wx, output logic [15:0] wy,
                           output int low, output int done_dly, output int busy_cnt,
                           output int t_start, output bit aborted);
        int n;
        int falls;
        logic prev_sclk;
        wx = '0; wy = '0; low = 0; done_dly = -1; busy_cnt = 0; t_start = cyc;
        aborted = 1'b0; falls = 0; n = 0;
        while (dac_sync_n === 1'b0 && n < 300) begin @(negedge clk); n++; end
        n = 0;
        while (dac_sync_n !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            n_vec++; n_miss++;
            $display("FAIL frame_start_timeout: no sync fall within 300 cycles");
            return;
        end
        t_start = cyc;
        prev_sclk = dac_sclk;
        n = 0;
        while (done_dly < 0 && n < 300) begin
            if (dac_sync_n === 1'b0) low++;
            if (busy === 1'b1) busy_cnt++;
            if (prev_sclk === 1'b1 && dac_sclk === 1'b0) begin
                wx = {wx[14:0], dac_dx};
                wy = {wy[14:0], dac_dy};
                falls++;
                if (falls == act_fall) begin
                    if (act_kind == 1) xch_in = act_val;
                    if (act_kind == 2) en = 1'b0;
                    if (act_kind == 3) begin
                        rst = 1'b1;
                        @(negedge clk);
                        rst = 1'b0;
                        chk("rst_mid_sync_n", {31'd0, dac_sync_n}, 32'd1);
                        chk("rst_mid_sclk", {31'd0, dac_sclk}, 32'd1);
                        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
                        aborted = 1'b1;
                        return;
                    end
                end
            end
            if (frame_done === 1'b1) done_dly = cyc - t_start;
            prev_sclk = dac_sclk;
            if (done_dly < 0) begin @(negedge clk); n++; end
        end
    endtask

    initial begin
        logic [15:0] wx, wy;
        int low, dly, bcnt, t0, t1;
        bit ab, good;

        tbl[0] = '{8'hA5, 8'h3C, 16'h0A50, 16'h03C0};
        tbl[1] = '{8'h00, 8'hFF, 16'h0000, 16'h0FF0};
        tbl[2] = '{8'hFF, 8'h00, 16'h0FF0, 16'h0000};
        tbl[3] = '{8'h80, 8'h01, 16'h0800, 16'h0010};
        tbl[4] = '{8'h55, 8'hAA, 16'h0550, 16'h0AA0};

        // Reset held three cycles with en high.
        repeat (3) @(negedge clk);
        chk("reset_sync_n", {31'd0, dac_sync_n}, 32'd1);
        chk("reset_sclk", {31'd0, dac_sclk}, 32'd1);
        chk("reset_dx", {31'd0, dac_dx}, 32'd0);
        chk("reset_dy", {31'd0, dac_dy}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_fall_after_release", {31'd0, dac_sync_n}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            xch_in = tbl[i].x;
            ych_in = tbl[i].y;
            capture(0, 0, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
            capture(0, 0, 8'h00, wx, wy, low, dly, bcnt, t1, ab);
            chk($sformatf("vec%0d_x_word", i), {16'd0, wx}, {16'd0, tbl[i].wx});
            chk($sformatf("vec%0d_y_word", i), {16'd0, wy}, {16'd0, tbl[i].wy});
            chk($sformatf("vec%0d_sync_low", i), low, 32'd64);
            chk($sformatf("vec%0d_done_delay", i), dly, 32'd68);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 32'd68);
            chk($sformatf("vec%0d_period", i), t1 - t0, 32'd69);
        end

        // Single-cycle glitch on X must never reach x_stable.
        xch_in = 8'h10;
        ych_in = 8'h00;
        capture(0, 0, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
        capture(0, 0, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
        xch_in = 8'hFF;
        @(negedge clk);
        xch_in = 8'h10;
        good = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dut.x_stable !== 8'h10) good = 1'b0;
        end
        chk("glitch_x_stable_held", {31'd0, good}, 32'd1);
        capture(0, 0, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
        chk("glitch_frame1_x", {16'd0, wx}, 32'h0100);
        capture(0, 0, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
        chk("glitch_frame2_x", {16'd0, wx}, 32'h0100);

        // X changes mid-frame: current frame unaffected, next frame picks it up.
        capture(8, 1, 8'h20, wx, wy, low, dly, bcnt, t0, ab);
        chk("midframe_cur_x", {16'd0, wx}, 32'h0100);
        capture(0, 0, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
        chk("midframe_next_x", {16'd0, wx}, 32'h0200);

        // Enable drop during the frame: frame completes, then stays idle.
        capture(5, 2, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
        chk("endrop_x_word", {16'd0, wx}, 32'h0200);
        chk("endrop_sync_low", low, 32'd64);
        chk("endrop_done_delay", dly, 32'd68);
        good = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dac_sync_n !== 1'b1 || busy !== 1'b0) good = 1'b0;
        end
        chk("endrop_stays_idle", {31'd0, good}, 32'd1);
        en = 1'b1;

        // Reset pulse during bit 7, then complete frames resume.
        capture(8, 3, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
        chk("rst_mid_aborted", {31'd0, ab}, 32'd1);
        capture(0, 0, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
        chk("post_rst_sync_low", low, 32'd64);
        chk("post_rst_done_delay", dly, 32'd68);
        capture(0, 0, 8'h00, wx, wy, low, dly, bcnt, t0, ab);
        chk("post_rst_x_word", {16'd0, wx}, 32'h0200);
        chk("post_rst_y_word", {16'd0, wy}, 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
